// File: rtl/column_adc_responder_if.sv
// Conversion handshake, comparator inputs and readout stream between the row
// sequencer / column front-end and the column ADC responder.
interface column_adc_responder_if #(
    parameter int unsigned columns   = 2,
    parameter int unsigned adc_bits  = 8,
    parameter int unsigned col_width = 1
);
    logic                  adc_enable;
    logic [columns-1:0]    comp_in;
    logic                  data_ready;
    logic [adc_bits-1:0]   ramp_code;
    logic                  ramp_active;
    logic [adc_bits-1:0]   data_out;
    logic [col_width-1:0]  data_col;
    logic                  data_valid;
    logic                  done;

    // Sequencer / front-end / downstream side
    modport master (
        output adc_enable,
        output comp_in,
        output data_ready,
        input  ramp_code,
        input  ramp_active,
        input  data_out,
        input  data_col,
        input  data_valid,
        input  done
    );

    // Responder side
    modport slave (
        input  adc_enable,
        input  comp_in,
        input  data_ready,
        output ramp_code,
        output ramp_active,
        output data_out,
        output data_col,
        output data_valid,
        output done
    );
endinterface

// File: rtl/column_adc_responder.sv
// Single-slope column ADC responder: runs a digital ramp, latches each
// column's code on its first comparator trip, streams the results out and
// signals done back to the row sequencer.
module column_adc_responder #(
    parameter int unsigned columns   = 2,
    parameter int unsigned adc_bits  = 8,
    parameter int unsigned col_width = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    column_adc_responder_if.slave bus
);
    localparam logic [col_width-1:0] LAST_COL   = col_width'(columns - 1);
    localparam logic [adc_bits-1:0]  FULL_SCALE = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        READOUT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [adc_bits-1:0]              ramp_code_q, ramp_code_d;
    logic                             ramp_active_q, ramp_active_d;
    logic [adc_bits-1:0]              data_out_q, data_out_d;
    logic [col_width-1:0]             data_col_q, data_col_d;
    logic                             data_valid_q, data_valid_d;
    logic                             done_q, done_d;
    logic [columns-1:0][adc_bits-1:0] value_q, value_d;
    logic [columns-1:0]               latched_q, latched_d;

    // State and output registers; reset discards any conversion in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ramp_code_q   <= '0;
            ramp_active_q <= 1'b0;
            data_out_q    <= '0;
            data_col_q    <= '0;
            data_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            value_q       <= '0;
            latched_q     <= '0;
        end else begin
            state_q       <= state_d;
            ramp_code_q   <= ramp_code_d;
            ramp_active_q <= ramp_active_d;
            data_out_q    <= data_out_d;
            data_col_q    <= data_col_d;
            data_valid_q  <= data_valid_d;
            done_q        <= done_d;
            value_q       <= value_d;
            latched_q     <= latched_d;
        end
    end

    // Next-state, ramp, column latch and readout logic
    always_comb begin
        state_d       = state_q;
        ramp_code_d   = ramp_code_q;
        ramp_active_d = ramp_active_q;
        data_out_d    = data_out_q;
        data_col_d    = data_col_q;
        data_valid_d  = data_valid_q;
        done_d        = done_q;
        value_d       = value_q;
        latched_d     = latched_q;

        case (state_q)
            IDLE: begin
                if (bus.adc_enable) begin
                    value_d       = '0;
                    latched_d     = '0;
                    ramp_code_d   = '0;
                    ramp_active_d = 1'b1;
                    state_d       = RAMP;
                end
            end

            RAMP: begin
                // First trip per column wins; later toggles are ignored
                for (int unsigned i = 0; i < columns; i++) begin
                    if (bus.comp_in[i] && !latched_q[i]) begin
                        value_d[i]   = ramp_code_q;
                        latched_d[i] = 1'b1;
                    end
                end
                if ((&latched_d) || (ramp_code_q == FULL_SCALE)) begin
                    // Columns that never tripped saturate at full scale
                    for (int unsigned i = 0; i < columns; i++) begin
                        if (!latched_d[i]) begin
                            value_d[i] = FULL_SCALE;
                        end
                    end
                    ramp_active_d = 1'b0;
                    ramp_code_d   = '0;
                    data_col_d    = '0;
                    data_out_d    = value_d[0];
                    data_valid_d  = 1'b1;
                    state_d       = READOUT;
                end else begin
                    ramp_code_d = ramp_code_q + 1'b1;
                end
            end

            READOUT: begin
                if (bus.data_ready) begin
                    if (data_col_q == LAST_COL) begin
                        data_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = DONE;
                    end else begin
                        data_col_d = data_col_q + 1'b1;
                        data_out_d = value_q[data_col_d];
                    end
                end
            end

            DONE: begin
                if (!bus.adc_enable) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Request withdrawn mid-conversion: drop everything, never report done
        if (((state_q == RAMP) || (state_q == READOUT)) && !bus.adc_enable) begin
            state_d       = IDLE;
            ramp_code_d   = '0;
            ramp_active_d = 1'b0;
            data_out_d    = '0;
            data_col_d    = '0;
            data_valid_d  = 1'b0;
            done_d        = 1'b0;
            value_d       = '0;
            latched_d     = '0;
        end
    end

    // Registered outputs onto the interface
    assign bus.ramp_code   = ramp_code_q;
    assign bus.ramp_active = ramp_active_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_col    = data_col_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_column_adc_responder.sv
// Bench for column_adc_responder: transaction-level reference model checked
// against the DUT every cycle, directed scenarios with literal expectations,
// then randomized conversions with comparator noise, backpressure and aborts.
module tb_column_adc_responder;
    localparam int COLS = 2;
    localparam int AB   = 4;
    localparam int CW   = 1;
    localparam int MAXC = (1 << AB) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    column_adc_responder_if #(.columns(COLS), .adc_bits(AB), .col_width(CW)) bus ();

    column_adc_responder #(.columns(COLS), .adc_bits(AB), .col_width(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 ramping, 2 reading out, 3 done
    int               ph      = 0;
    int               m_code  = 0;
    bit               m_act   = 0;
    int               m_out   = 0;
    int               m_col   = 0;
    bit               m_valid = 0;
    bit               m_done  = 0;
    int               res[COLS];
    logic [COLS-1:0]  hist[$];   // comparator sample per ramp step; index == ramp code

    // Result of a column = first ramp step it was seen high, else full scale
    function automatic int conv_result(input int c);
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k][c]) return k;
        end
        return MAXC;
    endfunction

    function automatic bit all_tripped();
        for (int c = 0; c < COLS; c++) begin
            bit hit = 0;
            for (int k = 0; k < hist.size(); k++) if (hist[k][c]) hit = 1;
            if (!hit) return 0;
        end
        return 1;
    endfunction

    task automatic model_clear();
        ph = 0; m_code = 0; m_act = 0; m_out = 0; m_col = 0; m_valid = 0; m_done = 0;
        hist.delete();
        for (int c = 0; c < COLS; c++) res[c] = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
        end else begin
            case (ph)
                0: if (bus.adc_enable) begin
                       ph = 1; m_code = 0; m_act = 1; hist.delete();
                   end
                1: if (!bus.adc_enable) model_clear();
                   else begin
                       hist.push_back(bus.comp_in);
                       if (all_tripped() || hist.size() == MAXC + 1) begin
                           for (int c = 0; c < COLS; c++) res[c] = conv_result(c);
                           ph = 2; m_act = 0; m_code = 0;
                           m_col = 0; m_valid = 1; m_out = res[0];
                       end else begin
                           m_code = hist.size();
                       end
                   end
                2: if (!bus.adc_enable) model_clear();
                   else if (bus.data_ready) begin
                       if (m_col == COLS - 1) begin
                           m_valid = 0; m_done = 1; ph = 3;
                       end else begin
                           m_col++; m_out = res[m_col];
                       end
                   end
                default: if (!bus.adc_enable) begin
                       m_done = 0; ph = 0;
                   end
            endcase
        end
    end

    // ---------------- stimulus drivers ----------------
    int              thr[COLS];
    bit              noise     = 0;
    bit              rdy_rand  = 0;
    bit              rdy_force = 1;
    logic [COLS-1:0] drv_comp;

    // Comparators trip once the model's ramp reaches a per-column threshold
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < COLS; c++) begin
            if (m_act) drv_comp[c] = (m_code >= thr[c]) || (noise && ($urandom_range(0, 15) == 0));
            else       drv_comp[c] = noise && ($urandom_range(0, 1) == 1);
        end
        bus.comp_in    = drv_comp;
        bus.data_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // ---------------- compare / monitor ----------------
    int acc_val[$];
    int acc_col[$];
    int ra_cnt     = 0;
    int max_code   = 0;
    bit seen_done  = 0;

    always @(negedge clk) begin
        chk("ramp_code",   int'(bus.ramp_code),   m_code);
        chk("ramp_active", int'(bus.ramp_active), int'(m_act));
        chk("data_valid",  int'(bus.data_valid),  int'(m_valid));
        chk("done",        int'(bus.done),        int'(m_done));
        chk("data_col",    int'(bus.data_col),    m_col);
        chk("data_out",    int'(bus.data_out),    m_out);
        if (bus.data_valid && bus.data_ready) begin
            acc_val.push_back(int'(bus.data_out));
            acc_col.push_back(int'(bus.data_col));
        end
        if (bus.ramp_active) begin
            ra_cnt++;
            if (int'(bus.ramp_code) > max_code) max_code = int'(bus.ramp_code);
        end
        if (bus.done) seen_done = 1;
    end

    // ---------------- helpers ----------------
    task automatic clear_stats();
        acc_val.delete(); acc_col.delete();
        ra_cnt = 0; max_code = 0; seen_done = 0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!bus.done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", int'(bus.done), 1);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!bus.data_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("valid_reached", int'(bus.data_valid), 1);
    endtask

    task automatic check_acc(input int v0, input int v1);
        chk("accepted_count", acc_val.size(), 2);
        if (acc_val.size() == 2) begin
            chk("col0_index", acc_col[0], 0);
            chk("col0_value", acc_val[0], v0);
            chk("col1_index", acc_col[1], 1);
            chk("col1_value", acc_val[1], v1);
        end
    endtask

    task automatic release_enable();
        @(posedge clk); #1 bus.adc_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.adc_enable = 1'b0;
        bus.comp_in    = '0;
        bus.data_ready = 1'b1;
        drv_comp       = '0;
        for (int c = 0; c < COLS; c++) thr[c] = 99;

        // Reset state
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_ramp_code",   int'(bus.ramp_code),   0);
        chk("rst_ramp_active", int'(bus.ramp_active), 0);
        chk("rst_data_valid",  int'(bus.data_valid),  0);
        chk("rst_done",        int'(bus.done),        0);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;

        // Trips at 5 and 9, downstream always ready
        thr[0] = 5; thr[1] = 9; rdy_force = 1; clear_stats();
        bus.adc_enable = 1'b1;
        wait_done(60);
        check_acc(5, 9);
        @(posedge clk); #1 bus.adc_enable = 1'b0;
        @(negedge clk);
        chk("done_held_before_drop_seen", int'(bus.done), 1);
        @(negedge clk);
        chk("done_cleared", int'(bus.done), 0);
        @(posedge clk); #1;

        // No comparator ever trips: full 16-step ramp, both saturate
        thr[0] = 99; thr[1] = 99; clear_stats();
        bus.adc_enable = 1'b1;
        wait_done(60);
        check_acc(15, 15);
        chk("full_ramp_cycles", ra_cnt, 16);
        chk("full_ramp_max_code", max_code, 15);
        release_enable();

        // Both comparators high on the first ramp step
        thr[0] = 0; thr[1] = 0; clear_stats();
        bus.adc_enable = 1'b1;
        wait_done(30);
        check_acc(0, 0);
        chk("early_exit_ramp_cycles", ra_cnt, 1);
        release_enable();

        // Backpressure: hold data_ready low for three readout cycles
        thr[0] = 5; thr[1] = 9; rdy_force = 0; clear_stats();
        bus.adc_enable = 1'b1;
        wait_valid(60);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", int'(bus.data_valid), 1);
            chk("stall_col",   int'(bus.data_col),   0);
            chk("stall_out",   int'(bus.data_out),   5);
        end
        rdy_force = 1;
        wait_done(30);
        check_acc(5, 9);
        release_enable();

        // Abort at ramp code 7, then restart from 0
        thr[0] = 99; thr[1] = 99; clear_stats();
        bus.adc_enable = 1'b1;
        begin
            int n = 0;
            while (!(m_act && m_code == 7) && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("abort_point_reached", m_code, 7);
        end
        bus.adc_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_ramp_code",   int'(bus.ramp_code),   0);
        chk("abort_ramp_active", int'(bus.ramp_active), 0);
        chk("abort_done",        int'(bus.done),        0);
        @(posedge clk); #1 bus.adc_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_code0",   int'(bus.ramp_code),   0);
        chk("restart_active",  int'(bus.ramp_active), 1);
        @(negedge clk);
        chk("restart_code1",   int'(bus.ramp_code),   1);
        wait_done(60);
        check_acc(15, 15);
        release_enable();

        // Asynchronous reset in the middle of readout
        thr[0] = 5; thr[1] = 9; rdy_force = 0; clear_stats();
        bus.adc_enable = 1'b1;
        wait_valid(60);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_ramp_code",  int'(bus.ramp_code),  0);
        chk("arst_data_out",   int'(bus.data_out),   0);
        chk("arst_data_col",   int'(bus.data_col),   0);
        chk("arst_data_valid", int'(bus.data_valid), 0);
        chk("arst_done",       int'(bus.done),       0);
        bus.adc_enable = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        rdy_force = 1; clear_stats();
        bus.adc_enable = 1'b1;
        wait_done(60);
        check_acc(5, 9);
        release_enable();

        // Randomized conversions: noisy comparators, random backpressure, aborts
        noise = 1; rdy_rand = 1;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < COLS; c++) thr[c] = $urandom_range(0, 20);
            clear_stats();
            bus.adc_enable = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 25)) @(posedge clk);
                #1 bus.adc_enable = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end else begin
                wait_done(200);
                chk("rand_accepted_count", acc_val.size(), COLS);
                if (acc_val.size() == COLS) begin
                    for (int c = 0; c < COLS; c++) begin
                        chk("rand_col_index", acc_col[c], c);
                        chk("rand_col_value", acc_val[c], res[c]);
                    end
                end
                @(posedge clk); #1 bus.adc_enable = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case anything above stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/column_adc_responder.md
Name: column_adc_responder

Overview:
- Conversion-side responder to the pixel row sequencer's `adc_enable`/`done` handshake.
- Each request runs one single-slope conversion on all columns of the selected row:
  - drives a digital ramp code to the ramp DAC;
  - latches each column's code when its comparator trips;
  - streams the column results out with a valid/ready handshake;
  - then raises `done` and holds it until the sequencer drops `adc_enable`.

Parameters:
- `columns`, 2, number of pixel columns converted in parallel.
- `adc_bits`, 8, conversion resolution. Ramp runs 0 .. 2**adc_bits-1.
- `col_width`, 1, width of the column index output. Must be ≥ clog2(`columns`), minimum 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `adc_enable`  in  1  conversion request from the row sequencer; level-held.
- `comp_in`  in  `columns`  per-column comparator outputs. 1 = pixel voltage crossed ramp. Synchronous to `clk`.
- `data_ready`  in  1  downstream accepts `data_out` this cycle.
- `ramp_code`  out  `adc_bits`  code to ramp DAC.
- `ramp_active`  out  1  high while the ramp is running.
- `data_out`  out  `adc_bits`  converted value of column `data_col`.
- `data_col`  out  `col_width`  column index of `data_out`.
- `data_valid`  out  1  `data_out`/`data_col` are valid.
- `done`  out  1  conversion and readout complete. Held high until `adc_enable`=0.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=IDLE;
  - `ramp_code`=0, `ramp_active`=0, `data_out`=0, `data_col`=0, `data_valid`=0, `done`=0;
  - all latch registers and latched flags cleared.
  - Reset mid-conversion discards all results.
- States: IDLE, RAMP, READOUT, DONE.
- IDLE:
  - If `adc_enable`=1: clear all latched flags and values, set `ramp_code`=0 and `ramp_active`=1, go to RAMP.
- RAMP, each cycle:
  - For every column i with `comp_in[i]`=1 and not yet latched: value[i] ← current `ramp_code`; set flag[i]. First trip wins; later toggles are ignored.
  - If all flags are set after this cycle's updates, or `ramp_code`=2**adc_bits-1:
    - every unlatched column gets value = 2**adc_bits-1 (saturation);
    - `ramp_active`←0, `ramp_code`←0;
    - go to READOUT with `data_col`=0, `data_valid`=1.
  - Otherwise `ramp_code` increments by 1.
  - Full-scale ramp = 2**adc_bits cycles in RAMP.
- READOUT:
  - `data_out` = value[`data_col`], `data_valid`=1.
  - On `data_valid`&`data_ready`:
    - if `data_col`=`columns`-1: `data_valid`←0, `done`←1, go to DONE;
    - else `data_col` increments.
  - `data_out`/`data_col` remain stable while `data_ready`=0.
- DONE:
  - `done`=1.
  - When `adc_enable`=0: `done`←0, go to IDLE.
  - A new request needs `adc_enable` low for at least one cycle after `done`.
- Abort:
  - `adc_enable`=0 in RAMP or READOUT → next cycle IDLE, all outputs at reset values.
  - `done` is never asserted for an aborted conversion.
- Simultaneous events:
  - Comparator trip on the final ramp code latches that code, not the saturation value; the result is identical.
  - All columns tripping in the same cycle triggers the early exit that same cycle.
- `comp_in` is ignored outside RAMP.

Test Plan:
- (`adc_bits`=4, `columns`=2) `adc_enable`=1; `comp_in[0]` rises when `ramp_code`=5, `comp_in[1]` when `ramp_code`=9; `data_ready`=1
  - → readout col0=5, col1=9 on consecutive cycles;
  - `done`=1 the cycle after col1 is accepted;
  - `done` clears one cycle after `adc_enable`=0.
- No comparator ever trips
  - → RAMP lasts 16 cycles with `ramp_code` 0..15;
  - both columns read 15;
  - `done` asserted.
- Both comparators high from the first RAMP cycle
  - → both latch 0;
  - RAMP exits after one cycle;
  - `ramp_active` high for exactly one cycle.
- `data_ready` held 0 for 3 cycles during READOUT
  - → `data_valid`=1 and `data_col`=0 / `data_out`=5 stable throughout;
  - readout resumes unchanged when `data_ready`=1.
- `adc_enable` dropped at `ramp_code`=7
  - → IDLE next cycle, `ramp_code`=0, `done` never 1;
  - re-raising `adc_enable` starts a fresh ramp at 0.
- `reset` pulsed low asynchronously mid-READOUT
  - → all outputs 0 immediately;
  - after release, a normal conversion completes correctly.
